// File: rtl/meter_pkg.sv
// meter_pkg: shared types and constants for square_wave_meter.
//   meter_state_t : FSM encoding {IDLE, HIGH, LOW}
//   CNT_W_DEF     : default counter / result width
//   MIN_RST_VAL   : all-ones reset value for the running minimum (sliced to CNT_W)
package meter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } meter_state_t;

   localparam int CNT_W_DEF = 20;

   // Wide enough for any practical CNT_W; users take the low CNT_W bits.
   localparam logic [63:0] MIN_RST_VAL = '1;

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: multi-flop synchroniser for an asynchronous level plus
// single-cycle rise/fall strobes on the synchronised level.
//   clk_in   in  clock, posedge
//   reset    in  synchronous active-high reset, clears every flop
//   async_in in  asynchronous input
//   level    out synchronised level (last synchroniser stage)
//   rise     out level & ~level_d
//   fall     out ~level & level_d
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_in,
   input  logic reset,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   level_d;

   always_ff @(posedge clk_in) begin
      if (reset) begin
         sync_q  <= '0;
         level_d <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
         level_d <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~level_d;
   assign fall  = ~level & level_d;

endmodule

// File: rtl/square_wave_meter.sv
// square_wave_meter: measures period and high time of a slow square wave in
// clk_in cycles and hands each result out over a valid/ready port.
//   clk_in      in  clock, posedge
//   reset       in  synchronous active-high reset
//   sig_in      in  asynchronous square wave
//   meas_valid  out result held and not yet accepted
//   meas_ready  in  consumer accept (meas_valid && meas_ready)
//   period      out cycles rise-to-rise
//   high_time   out cycles rise-to-fall
//   stalled     out no required edge within TIMEOUT cycles
//   overrun     out sticky, a result was dropped while meas_valid was high
// Optional build macro METER_MINMAX_EN adds period_min / period_max, the
// running extremes over every loaded result.
module square_wave_meter
   import meter_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int TIMEOUT     = 1_000_000,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             sig_in,
   output logic             meas_valid,
   input  logic             meas_ready,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             stalled,
   output logic             overrun
`ifdef METER_MINMAX_EN
   ,
   output logic [CNT_W-1:0] period_min,
   output logic [CNT_W-1:0] period_max
`endif
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic sig_level, rise, fall;

   sync_edge_detect #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk_in  (clk_in),
      .reset   (reset),
      .async_in(sig_in),
      .level   (sig_level),
      .rise    (rise),
      .fall    (fall)
   );

   // The meter works purely from the edge strobes; the level is not needed.
   logic unused_level;
   assign unused_level = sig_level;

   meter_state_t     state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] hi_cap, hi_cap_nxt;
   logic [CNT_W-1:0] cnt_inc;
   logic             done, arm, timeout;

   assign cnt_inc = cnt + CNT_ONE;

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         hi_cap <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         hi_cap <= hi_cap_nxt;
      end
   end

   // Timeout is checked ahead of the edges, so cnt never reaches TIMEOUT
   // and a late edge on the expiring cycle is treated as a stall.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      hi_cap_nxt = hi_cap;
      done       = 1'b0;
      arm        = 1'b0;
      timeout    = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (rise) begin
               state_nxt = HIGH;
               arm       = 1'b1;
            end
         end
         HIGH: begin
            if (cnt == CNT_LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               timeout   = 1'b1;
            end else begin
               cnt_nxt = cnt_inc;
               if (fall) begin
                  hi_cap_nxt = cnt_inc;
                  state_nxt  = LOW;
               end
            end
         end
         LOW: begin
            if (cnt == CNT_LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               timeout   = 1'b1;
            end else if (rise) begin
               done      = 1'b1;
               cnt_nxt   = '0;
               state_nxt = HIGH;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // A new result may be loaded when the slot is empty or is being
   // accepted this very cycle; otherwise it is dropped and flagged.
   logic load;
   assign load = done & (~meas_valid | meas_ready);

   always_ff @(posedge clk_in) begin
      if (reset) begin
         meas_valid <= 1'b0;
         period     <= '0;
         high_time  <= '0;
         stalled    <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (timeout)
            stalled <= 1'b1;
         else if (arm)
            stalled <= 1'b0;

         if (load) begin
            period     <= cnt_inc;
            high_time  <= hi_cap;
            meas_valid <= 1'b1;
         end else if (done) begin
            overrun <= 1'b1;
         end else if (meas_valid && meas_ready) begin
            meas_valid <= 1'b0;
         end
      end
   end

`ifdef METER_MINMAX_EN
   always_ff @(posedge clk_in) begin
      if (reset) begin
         period_min <= MIN_RST_VAL[CNT_W-1:0];
         period_max <= '0;
      end else if (load) begin
         if (cnt_inc < period_min) period_min <= cnt_inc;
         if (cnt_inc > period_max) period_max <= cnt_inc;
      end
   end
`else
   // Min/max tracking not built.
`endif

endmodule

// File: tb/tb_square_wave_meter.sv
module tb_square_wave_meter;

   localparam int CNT_W   = 20;
   localparam int TIMEOUT = 64;
   localparam int SYNC    = 2;

   logic             clk_in = 1'b0;
   logic             reset;
   logic             sig_in;
   logic             meas_valid;
   logic             meas_ready;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             stalled;
   logic             overrun;
`ifdef METER_MINMAX_EN
   logic [CNT_W-1:0] period_min;
   logic [CNT_W-1:0] period_max;
`endif

   square_wave_meter #(
      .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .SYNC_STAGES(SYNC)
   ) dut (
      .clk_in    (clk_in),
      .reset     (reset),
      .sig_in    (sig_in),
      .meas_valid(meas_valid),
      .meas_ready(meas_ready),
      .period    (period),
      .high_time (high_time),
      .stalled   (stalled),
      .overrun   (overrun)
`ifdef METER_MINMAX_EN
      ,
      .period_min(period_min),
      .period_max(period_max)
`endif
   );

   always #5 clk_in = ~clk_in;

   int total = 0;
   int bad   = 0;
   int hs_cnt = 0;
   bit mon_en = 1'b0;

   typedef struct {
      int p;
      int h;
   } res_t;
   res_t expq[$];
   res_t mon_e;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Scoreboard: every accepted result must match the next segment pair.
   always @(negedge clk_in) begin
      if (mon_en && meas_valid && meas_ready) begin
         hs_cnt++;
         total++;
         assert (expq.size() != 0) else begin
            bad++;
            $error("FAIL hs_unexpected observed=%0d expected=none", period);
         end
         if (expq.size() != 0) begin
            mon_e = expq.pop_front();
            chk("hs_period", 32'(period), mon_e.p);
            chk("hs_high", 32'(high_time), mon_e.h);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic seg(input bit v, input int n);
      sig_in = v;
      cyc(n);
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      sig_in = 1'b0;
      cyc(2);
      reset  = 1'b0;
   endtask

   // First rise arms; each later rise completes (h+l, h) of the prior pair.
   task automatic run_wave(input string tag, input int n, input bit rnd);
      int h, l;
      do_reset();
      meas_ready = 1'b1;
      hs_cnt = 0;
      expq.delete();
      mon_en = 1'b1;
      seg(1'b0, 5);
      h = rnd ? int'($urandom_range(30, 2)) : 4;
      seg(1'b1, h);
      for (int i = 0; i < n; i++) begin
         l = rnd ? int'($urandom_range(30, 2)) : 4;
         seg(1'b0, l);
         expq.push_back('{p: h + l, h: h});
         h = rnd ? int'($urandom_range(30, 2)) : 4;
         seg(1'b1, h);
      end
      cyc(4);
      mon_en = 1'b0;
      chk({tag, "_pulses"}, hs_cnt, n);
      chk({tag, "_left"}, expq.size(), 0);
      chk({tag, "_overrun"}, 32'(overrun), 0);
      chk({tag, "_stalled"}, 32'(stalled), 0);
   endtask

   initial begin
      reset      = 1'b1;
      sig_in     = 1'b0;
      meas_ready = 1'b0;
      cyc(3);
      chk("rst_valid", 32'(meas_valid), 0);
      chk("rst_period", 32'(period), 0);
      chk("rst_high", 32'(high_time), 0);
      chk("rst_stalled", 32'(stalled), 0);
      chk("rst_overrun", 32'(overrun), 0);
`ifdef METER_MINMAX_EN
      chk("rst_min", 32'(period_min), (1 << CNT_W) - 1);
      chk("rst_max", 32'(period_max), 0);
`endif
      reset = 1'b0;

      // fixed 4/4 toggling, ready held high
      run_wave("t1", 6, 1'b0);

      // random high/low lengths against the arithmetic model
      run_wave("rnd", 12, 1'b1);

      // ready low: first result held, second dropped with overrun
      do_reset();
      meas_ready = 1'b0;
      seg(1'b0, 4);
      seg(1'b1, 3);
      seg(1'b0, 7);
      seg(1'b1, 3);
      seg(1'b0, 2);
      chk("t2_valid", 32'(meas_valid), 1);
      chk("t2_period", 32'(period), 10);
      chk("t2_high", 32'(high_time), 3);
      chk("t2_overrun0", 32'(overrun), 0);
      seg(1'b0, 5);
      seg(1'b1, 3);
      seg(1'b0, 3);
      chk("t2_overrun1", 32'(overrun), 1);
      chk("t2_period_held", 32'(period), 10);
      chk("t2_high_held", 32'(high_time), 3);
      chk("t2_valid_held", 32'(meas_valid), 1);

      // stall: held high, stall 64 cycles after counting starts
      do_reset();
      seg(1'b0, 4);
      sig_in = 1'b1;
      cyc(66);
      chk("t3_not_yet", 32'(stalled), 0);
      cyc(1);
      chk("t3_stalled", 32'(stalled), 1);
      cyc(TIMEOUT + 5 - 67);
      chk("t3_no_valid", 32'(meas_valid), 0);
      seg(1'b0, 10);
      chk("t3_fall_keeps", 32'(stalled), 1);
      sig_in = 1'b1;
      cyc(3);
      chk("t3_cleared", 32'(stalled), 0);
      chk("t3_no_valid2", 32'(meas_valid), 0);

      // accept on the same cycle as a new result lands
      do_reset();
      meas_ready = 1'b0;
      seg(1'b0, 4);
      seg(1'b1, 3);
      seg(1'b0, 7);
      seg(1'b1, 5);
      seg(1'b0, 2);
      chk("t4_first", 32'(period), 10);
      seg(1'b0, 7);
      sig_in = 1'b1;
      cyc(2);
      meas_ready = 1'b1;
      cyc(1);
      meas_ready = 1'b0;
      chk("t4_valid", 32'(meas_valid), 1);
      chk("t4_period", 32'(period), 14);
      chk("t4_high", 32'(high_time), 5);
      chk("t4_overrun", 32'(overrun), 0);
      cyc(2);
      chk("t4_valid_stays", 32'(meas_valid), 1);

      // reset while in LOW with a pending result
      seg(1'b1, 2);
      seg(1'b0, 4);
      reset = 1'b1;
      cyc(1);
      chk("t5_valid", 32'(meas_valid), 0);
      chk("t5_period", 32'(period), 0);
      chk("t5_high", 32'(high_time), 0);
      chk("t5_stalled", 32'(stalled), 0);
      chk("t5_overrun", 32'(overrun), 0);
      reset = 1'b0;
      seg(1'b1, 4);
      seg(1'b0, 4);
      chk("t5_arm_only", 32'(meas_valid), 0);
      seg(1'b1, 4);
      chk("t5_valid_after", 32'(meas_valid), 1);
      chk("t5_period_after", 32'(period), 8);
      chk("t5_high_after", 32'(high_time), 4);

`ifdef METER_MINMAX_EN
      // running extremes over periods 8, 12, 6
      do_reset();
      meas_ready = 1'b1;
      hs_cnt = 0;
      expq.delete();
      mon_en = 1'b1;
      seg(1'b0, 4);
      seg(1'b1, 4);
      seg(1'b0, 4);
      expq.push_back('{p: 8, h: 4});
      seg(1'b1, 6);
      seg(1'b0, 6);
      expq.push_back('{p: 12, h: 6});
      seg(1'b1, 3);
      seg(1'b0, 3);
      expq.push_back('{p: 6, h: 3});
      seg(1'b1, 3);
      cyc(4);
      mon_en = 1'b0;
      chk("t6_pulses", hs_cnt, 3);
      chk("t6_min", 32'(period_min), 6);
      chk("t6_max", 32'(period_max), 12);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
